// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder sequencer: radix-2 restoring divider with sign fix-up and pipeline stall.
// Optional macro DIV_EARLY_OUT_EN enables a one-cycle shortcut when |Rs1| < |Rs2|.
module div_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            CLK,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] Rs1,
   input  logic [XLEN-1:0] Rs2,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   state_t            r_state;
   state_t            w_nextState;

   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_div;
   logic [CNT_W-1:0]  r_count;
   logic              r_isRem;
   logic              r_negQ;
   logic              r_negR;
   logic [XLEN-1:0]   r_result;

   logic              w_unused;
   logic              w_signed;
   logic              w_neg1;
   logic              w_neg2;
   logic [XLEN-1:0]   w_mag1;
   logic [XLEN-1:0]   w_mag2;
   logic              w_divZero;
   logic              w_overflow;
   logic              w_early;
   logic              w_special;
   logic [XLEN-1:0]   w_specialResult;
   logic [XLEN:0]     w_shiftRem;
   logic [XLEN:0]     w_trial;
   logic              w_trialOk;
   logic [XLEN-1:0]   w_newRem;
   logic [XLEN-1:0]   w_newQuo;
   logic [XLEN-1:0]   w_quoFinal;
   logic [XLEN-1:0]   w_remFinal;

   // Funct3[2] is guaranteed set by the decoder whenever start is raised
   assign w_unused   = Funct3[2];

   assign w_signed   = ~Funct3[0];
   assign w_neg1     = w_signed & Rs1[XLEN-1];
   assign w_neg2     = w_signed & Rs2[XLEN-1];
   assign w_mag1     = w_neg1 ? (~Rs1 + 1'b1) : Rs1;
   assign w_mag2     = w_neg2 ? (~Rs2 + 1'b1) : Rs2;
   assign w_divZero  = (Rs2 == '0);
   assign w_overflow = w_signed & (Rs1 == MIN_INT) & (Rs2 == '1);

`ifdef DIV_EARLY_OUT_EN
   assign w_early    = ~w_divZero & (w_mag1 < w_mag2);
`else
   assign w_early    = 1'b0;
`endif

   assign w_special  = w_divZero | w_overflow | w_early;

   // Results of the cases that bypass the iterative loop
   always_comb begin
      w_specialResult = '0;
      if (w_divZero)
         w_specialResult = Funct3[1] ? Rs1 : '1;
      else if (w_overflow)
         w_specialResult = Funct3[1] ? '0 : MIN_INT;
      else if (w_early)
         w_specialResult = Funct3[1] ? Rs1 : '0;
   end

   // Remainder never exceeds the divisor, so the XLEN+1-bit trial difference cannot wrap
   assign w_shiftRem = {r_rem, r_quo[XLEN-1]};
   assign w_trial    = w_shiftRem - {1'b0, r_div};
   assign w_trialOk  = ~w_trial[XLEN];
   assign w_newRem   = w_trialOk ? w_trial[XLEN-1:0] : w_shiftRem[XLEN-1:0];
   assign w_newQuo   = {r_quo[XLEN-2:0], w_trialOk};

   assign w_quoFinal = r_negQ ? (~r_quo + 1'b1) : r_quo;
   assign w_remFinal = r_negR ? (~r_rem + 1'b1) : r_rem;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start && !flush)
               w_nextState = w_special ? DONE : CALC;
         end
         CALC: begin
            if (flush)
               w_nextState = IDLE;
            else if (r_count == CNT_W'(1))
               w_nextState = FIX;
         end
         FIX:     w_nextState = flush ? IDLE : DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Accept-cycle stall is combinational so the instruction is frozen in EX immediately
   always_comb begin
      stall = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (r_state)
         IDLE:    stall = start & ~flush;
         CALC:    begin stall = 1'b1; busy = 1'b1; end
         FIX:     begin stall = 1'b1; busy = 1'b1; end
         DONE:    begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_quo    <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_count  <= '0;
         r_isRem  <= 1'b0;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !flush) begin
                  r_isRem <= Funct3[1];
                  r_negQ  <= w_neg1 ^ w_neg2;
                  r_negR  <= w_neg1;
                  r_quo   <= w_mag1;
                  r_div   <= w_mag2;
                  r_rem   <= '0;
                  r_count <= CNT_W'(XLEN);
                  if (w_special)
                     r_result <= w_specialResult;
               end
            end
            CALC: begin
               r_rem   <= w_newRem;
               r_quo   <= w_newQuo;
               r_count <= r_count - 1'b1;
            end
            FIX: begin
               if (!flush)
                  r_result <= r_isRem ? w_remFinal : w_quoFinal;
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, stall window, signed/unsigned results,
// special cases, flush, asynchronous reset and the optional early-out path.
module tb_div_sequencer;

   logic        CLK;
   logic        rst_n;
   logic        start;
   logic [2:0]  Funct3;
   logic [31:0] Rs1;
   logic [31:0] Rs2;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   int lat;
   int stallCnt;
   int doneCnt;

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;

`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 34;
`endif

   div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
      .CLK    (CLK),
      .rst_n  (rst_n),
      .start  (start),
      .Funct3 (Funct3),
      .Rs1    (Rs1),
      .Rs2    (Rs2),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Pulses start for one cycle and reports the done cycle (-1 on timeout) and stalled cycles
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                output int doneCyc, output int stallCyc);
      int cyc;
      @(negedge CLK);
      Funct3 = f3;
      Rs1    = a;
      Rs2    = b;
      start  = 1'b1;
      #1;
      stallCyc = stall ? 1 : 0;
      doneCyc  = -1;
      cyc      = 0;
      while (cyc < 100 && doneCyc < 0) begin
         @(posedge CLK);
         #1;
         start = 1'b0;
         cyc++;
         if (done)
            doneCyc = cyc;
         else if (stall)
            stallCyc++;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      Funct3 = 3'b000;
      Rs1    = '0;
      Rs2    = '0;

      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset_stall",  {31'd0, stall}, 32'd0);
      checkOutput("reset_busy",   {31'd0, busy},  32'd0);
      checkOutput("reset_done",   {31'd0, done},  32'd0);
      checkOutput("reset_result", result,         32'd0);
      @(negedge CLK);
      rst_n = 1'b1;

      applyStimulus(F_DIVU, 32'd100, 32'd7, lat, stallCnt);
      checkOutput("divu_latency", 32'(lat),      32'd34);
      checkOutput("divu_stall",   32'(stallCnt), 32'd34);
      checkOutput("divu_result",  result,        32'd14);

      applyStimulus(F_REM, 32'hFFFF_FF9C, 32'd7, lat, stallCnt);
      checkOutput("rem_neg_latency", 32'(lat), 32'd34);
      checkOutput("rem_neg_result",  result,   32'hFFFF_FFFE);

      applyStimulus(F_DIV, 32'hFFFF_FF9C, 32'd7, lat, stallCnt);
      checkOutput("div_neg_result", result, 32'hFFFF_FFF2);

      applyStimulus(F_DIV, 32'd7, 32'hFFFF_FFFE, lat, stallCnt);
      checkOutput("div_negdivisor", result, 32'hFFFF_FFFD);

      applyStimulus(F_REM, 32'd7, 32'hFFFF_FFFE, lat, stallCnt);
      checkOutput("rem_negdivisor", result, 32'd1);

      applyStimulus(F_DIVU, 32'hFFFF_FFFF, 32'd16, lat, stallCnt);
      checkOutput("divu_big", result, 32'h0FFF_FFFF);

      applyStimulus(F_REMU, 32'hFFFF_FFFF, 32'd16, lat, stallCnt);
      checkOutput("remu_big", result, 32'd15);

      applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, stallCnt);
      checkOutput("ovf_div_latency", 32'(lat), 32'd1);
      checkOutput("ovf_div_result",  result,   32'h8000_0000);

      applyStimulus(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, stallCnt);
      checkOutput("ovf_rem_result", result, 32'd0);

      applyStimulus(F_DIV, 32'd5, 32'd0, lat, stallCnt);
      checkOutput("dz_div_latency", 32'(lat),      32'd1);
      checkOutput("dz_div_stall",   32'(stallCnt), 32'd1);
      checkOutput("dz_div_result",  result,        32'hFFFF_FFFF);

      applyStimulus(F_REMU, 32'd5, 32'd0, lat, stallCnt);
      checkOutput("dz_remu_result", result, 32'd5);

      // Flush in cycle 10 of a DIVU 1000/3
      doneCnt = 0;
      @(negedge CLK);
      Funct3 = F_DIVU;
      Rs1    = 32'd1000;
      Rs2    = 32'd3;
      start  = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge CLK);
         #1;
         start = 1'b0;
         if (done) doneCnt++;
      end
      @(negedge CLK);
      flush = 1'b1;
      #1;
      checkOutput("flush_c10_stall", {31'd0, stall}, 32'd1);
      @(posedge CLK);
      #1;
      flush = 1'b0;
      if (done) doneCnt++;
      checkOutput("flush_c11_busy",   {31'd0, busy},  32'd0);
      checkOutput("flush_c11_stall",  {31'd0, stall}, 32'd0);
      checkOutput("flush_result_kept", result,        32'd5);
      checkOutput("flush_no_done",    32'(doneCnt),   32'd0);
      @(posedge CLK);
      #1;
      applyStimulus(F_DIVU, 32'd1000, 32'd3, lat, stallCnt);
      checkOutput("post_flush_latency", 32'(lat), 32'd34);
      checkOutput("post_flush_result",  result,   32'd333);

      // Asynchronous reset at cycle 20 of an operation
      doneCnt = 0;
      @(negedge CLK);
      Funct3 = F_DIVU;
      Rs1    = 32'd1000;
      Rs2    = 32'd3;
      start  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge CLK);
         #1;
         start = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_stall",  {31'd0, stall}, 32'd0);
      checkOutput("arst_busy",   {31'd0, busy},  32'd0);
      checkOutput("arst_result", result,         32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge CLK);
         #1;
         if (done) doneCnt++;
      end
      checkOutput("arst_no_done", 32'(doneCnt),  32'd0);
      checkOutput("arst_idle",    {31'd0, busy}, 32'd0);

      applyStimulus(F_DIVU, 32'd3, 32'd10, lat, stallCnt);
      checkOutput("small_latency", 32'(lat), 32'(EARLY_LAT));
      checkOutput("small_result",  result,   32'd0);

      applyStimulus(F_REMU, 32'd3, 32'd10, lat, stallCnt);
      checkOutput("small_rem_result", result, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder path in the EX stage.
- Captures operands when the control unit flags a divide, runs a radix-2 restoring divider for 32 iterations, and applies sign correction.
- Holds the pipeline via a stall output and returns the quotient or remainder to the EX result mux.
- Owns the FSM, iteration counter and the divider's working registers.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
CLK  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  divide instruction valid in EX (opcode 0110011, Funct7_0=1, Funct3[2]=1)
Funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
Rs1  input  XLEN  dividend
Rs2  input  XLEN  divisor
flush  input  1  pipeline flush; aborts any operation
stall  output  1  freeze PC/IF/ID/EX while high
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse, result valid
result  output  XLEN  quotient or remainder, held until next accepted start

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-low on rst_n.
- Reset, applied at any time including mid-operation:
  - FSM returns to IDLE; counter returns to 0.
  - stall=0, busy=0, done=0, result=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - A start is accepted when start=1 and flush=0.
  - stall=start&~flush, driven combinationally in the accept cycle (cycle 0).
  - On accept, latch the op and the operand signs. Latch |Rs1| and |Rs2| for signed ops; raw values for unsigned ops.
  - Clear the remainder register, load counter=XLEN, go to CALC.
- Special cases, decided in IDLE: the sequencer goes straight to DONE with the listed result and skips CALC.
  - Divide by zero (Rs2=0): quotient=all ones; remainder=Rs1.
  - Signed overflow (DIV/REM, Rs1=0x80000000, Rs2=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- CALC:
  - Each cycle: shift {rem,quo} left by 1, bringing in the dividend MSB.
  - Trial-subtract the divisor at XLEN+1 bits. If the result is non-negative, commit it and set the quotient LSB.
  - Decrement the counter. On counter reaching 1→0, go to FIX. This gives exactly XLEN CALC cycles.
  - stall=1.
- FIX (1 cycle, stall=1):
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign (signed ops only).
  - Select quotient or remainder by Funct3[1]; register into result.
- DONE (1 cycle):
  - done=1 and stall=0, so EX consumes result this cycle.
  - Return to IDLE.
- Latency: normal path done at cycle XLEN+2 (34), with stall high for cycles 0..33. Special-case path done at cycle 1, with stall high for cycle 0 only.
- flush in any non-IDLE state: next state is IDLE, with no done pulse and result unchanged. stall drops in the cycle after flush.
- flush and start in the same IDLE cycle: the start is ignored.
- start while busy: ignored; no queueing.
- busy=1 in CALC, FIX and DONE.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |Rs1| < |Rs2| (unsigned compare of latched magnitudes, Rs2≠0), go straight to DONE with quotient=0 and remainder=Rs1 unchanged. Latency is then 1 cycle, the same as the special cases.
- Undefined: no magnitude compare. These operands take the full 34-cycle path and produce the same numeric result.

Test Plan:
- DIVU Rs1=100, Rs2=7, start pulse at cycle 0 → stall high for cycles 0..33; done at cycle 34; result=14.
- REM Rs1=0xFFFFFF9C (−100), Rs2=7 → result=0xFFFFFFFE (−2) at cycle 34. DIV with the same operands → 0xFFFFFFF2 (−14).
- DIV Rs1=5, Rs2=0 → done at cycle 1, result=0xFFFFFFFF. REMU Rs1=5, Rs2=0 → result=5.
- DIV Rs1=0x80000000, Rs2=0xFFFFFFFF → result=0x80000000 at cycle 1. REM with the same operands → 0.
- Start DIVU 1000/3, assert flush at cycle 10 → busy=0 and stall=0 from cycle 11; no done; result keeps its prior value. A new start at cycle 12 is accepted.
- Drop rst_n at cycle 20 of an operation → outputs 0 immediately; no done after release.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → done at cycle 1, result=0. Without it: done at cycle 34, result=0.
